cursor_measure_engine: RTL and testbench
========================================

Name: cursor_measure_engine

Overview:
- Parametrised, multi-channel cursor measurement unit for the scope datapath.
- Takes the two cursor pairs plus per-channel vertical-scale (shiftDown) and sample-rate (sampleAdjust) settings.
- On a start pulse it computes one of: delta-time, delta-voltage or frequency (via an iterative divider).
- Sits between the cursor/UI logic and the seven-segment/overlay number display; replaces the single-shot button-clocked measurement.

Parameters:
- NUM_CH, 2, number of wave channels selectable.
- COORD_W, 11, cursor coordinate width.
- SHIFT_W, 4, per-channel vertical shrink setting width.
- RATE_W, 6, per-channel sample-rate setting width.
- RESULT_W, 14, result width (display range 0..2^RESULT_W-1).
- FREQ_NUM, 10000, numerator for frequency mode (RESULT_W bits).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- measurement  in  2  mode: 0 none, 1 delta-x time, 2 delta-y voltage, 3 frequency.
- waveSel  in  $clog2(NUM_CH) (min 1)  channel whose settings scale the result.
- cursorx1, cursorx2, cursory1, cursory2  in  COORD_W each  cursor positions.
- shiftDown  in  NUM_CH*SHIFT_W  flattened per-channel shrink; channel c at [c*SHIFT_W +: SHIFT_W].
- sampleAdjust  in  NUM_CH*RATE_W  flattened per-channel rate, same packing.
- busy  out  1  high from the accepted start until resultValid.
- resultValid  out  1  one-cycle pulse when result updates.
- result  out  RESULT_W  last completed measurement; held between completions.
- overflow  out  1  flag qualifying result; updates with resultValid.

Behaviour:
- Reset: result=0, resultValid=0, busy=0, overflow=0, FSM=IDLE. Reset is synchronous, active-high.
- FSM states: IDLE, DELTA, SCALE, DIVIDE, DONE.
- IDLE:
  - start=1 latches all inputs into registers, sets busy=1, goes to DELTA.
  - start while not IDLE is ignored (no queueing).
- DELTA: absolute differences |x1-x2| and |y1-y2|, unsigned, COORD_W bits; never negative. Goes to SCALE.
- SCALE (channel c = latched waveSel):
  - mode0: value 0.
  - mode1: |dx|*(sampleAdjust[c]+1).
  - mode2: |dy|*(shiftDown[c]+1)*2.
  - mode3: period = |dx|*(sampleAdjust[c]+1).
  - Products are computed at full width, then saturated to 2^RESULT_W-1 with overflow=1.
  - waveSel >= NUM_CH: value all-ones, overflow=1, mode3 divide skipped.
  - Exit: mode3 with a valid channel goes to DIVIDE; otherwise to DONE.
- DIVIDE:
  - Restoring divide FREQ_NUM/period, one quotient bit per cycle, RESULT_W cycles.
  - period==0 skips the divide: all-ones, overflow=1.
  - Exit: DONE.
- DONE: result/overflow registered, resultValid=1 for exactly this cycle, busy=0, then IDLE.
- Latency: start edge to resultValid is 3 cycles for modes 0-2, and for zero-period and invalid-channel cases. Mode3 with a divide takes 3+RESULT_W cycles (17 default).
- A new start may be accepted the cycle after DONE (back-to-back throughput: one measurement per 4 cycles).
- Reset mid-operation: aborts, no resultValid, outputs return to reset values.
- Input changes after acceptance do not affect the in-flight measurement.

Optional Feature:
- Macro: MEASURE_AUTO_EN.
- Defined:
  - Adds input autoRun (1 bit).
  - In DONE with autoRun=1, the FSM re-latches the current inputs and enters DELTA directly, so busy stays high apart from 1-cycle gaps. This gives a continuously refreshing display.
  - start remains functional.
- Undefined: port absent; measurements only on start.

Decomposition:
- Package measure_pkg holds:
  - mode encodings (MEAS_NONE, MEAS_TIME, MEAS_VOLT, MEAS_FREQ).
  - FSM state enum.
  - default width constants (COORD_W, RESULT_W).
  - saturation helper function.
- Sub-module measure_divider:
  - sequential restoring divider, parametrised on RESULT_W.
  - handshake: load/done.
  - owns the DIVIDE iteration count.

Test Plan:
- Voltage: mode2, y1=100, y2=40, waveSel=1, shiftDown[1]=3 -> result=480, overflow=0, resultValid 3 cycles after start.
- Time with swapped cursors: mode1, x1=10, x2=250, sampleAdjust[0]=4 -> result=1200; also check x1/x2 swapped gives the identical result.
- Frequency and divide-by-zero:
  - mode3, dx=100, sampleAdjust[0]=0 -> result=100 at 17 cycles.
  - dx=0 -> result=16383, overflow=1 at 3 cycles.
- Saturation: mode2, dy=2047, shiftDown=15 -> result=16383, overflow=1; next mode0 start -> result=0, overflow=0.
- Busy rules:
  - start pulsed mid-DIVIDE is ignored (exactly one resultValid).
  - reset asserted at divide cycle 5 yields no resultValid; result=0, busy=0.
- Auto mode (MEASURE_AUTO_EN defined), autoRun=1, mode1: resultValid every 4 cycles, tracking a changed x2 on the next cycle.

Source files
------------

// File: rtl/measure_pkg.sv
// Shared types and helpers for the cursor measurement engine: mode codes,
// FSM states, default widths and the saturation check.
package measure_pkg;

  localparam int MEAS_COORD_W  = 11;
  localparam int MEAS_RESULT_W = 14;

  typedef enum logic [1:0] {
    MEAS_NONE = 2'd0,
    MEAS_TIME = 2'd1,
    MEAS_VOLT = 2'd2,
    MEAS_FREQ = 2'd3
  } meas_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    DELTA,
    SCALE,
    DIVIDE,
    DONE
  } meas_state_e;

  // True when value does not fit in an unsigned field of the given width.
  function automatic logic sat_overflow(input logic [63:0] value, input int width);
    if (width >= 64) return 1'b0;
    return value > ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/cursor_measure_engine_if.sv
// Request/result bundle between the cursor UI logic (master) and the
// measurement engine (slave).
interface cursor_measure_engine_if #(
  parameter int NUM_CH   = 2,
  parameter int COORD_W  = 11,
  parameter int SHIFT_W  = 4,
  parameter int RATE_W   = 6,
  parameter int RESULT_W = 14
);
  localparam int WSEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       start;
  logic [1:0]                 measurement;
  logic [WSEL_W-1:0]          waveSel;
  logic [COORD_W-1:0]         cursorx1;
  logic [COORD_W-1:0]         cursorx2;
  logic [COORD_W-1:0]         cursory1;
  logic [COORD_W-1:0]         cursory2;
  logic [NUM_CH*SHIFT_W-1:0]  shiftDown;
  logic [NUM_CH*RATE_W-1:0]   sampleAdjust;
  logic                       busy;
  logic                       resultValid;
  logic [RESULT_W-1:0]        result;
  logic                       overflow;

  modport master (
    output start, measurement, waveSel, cursorx1, cursorx2, cursory1, cursory2,
           shiftDown, sampleAdjust,
    input  busy, resultValid, result, overflow
  );

  modport slave (
    input  start, measurement, waveSel, cursorx1, cursorx2, cursory1, cursory2,
           shiftDown, sampleAdjust,
    output busy, resultValid, result, overflow
  );
endinterface

// File: rtl/measure_divider.sv
// Sequential restoring divider, one quotient bit per clock. The load cycle
// already performs the first iteration, so done pulses RESULT_W-1 cycles later.
module measure_divider #(
  parameter int RESULT_W = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [RESULT_W-1:0] dividend,
  input  logic [RESULT_W-1:0] divisor,
  output logic                done,
  output logic [RESULT_W-1:0] quotient
);
  localparam int CNT_W = $clog2(RESULT_W + 1);

  logic [RESULT_W-1:0] remReg, quoReg, divReg;
  logic [CNT_W-1:0]    cntReg;
  logic                runReg, doneReg;

  logic [RESULT_W-1:0] remIn, quoIn, divIn, remOut, quoOut;
  logic [RESULT_W:0]   shifted, diff;

  always_comb begin
    remIn   = load ? '0 : remReg;
    quoIn   = load ? dividend : quoReg;
    divIn   = load ? divisor : divReg;
    shifted = {remIn, quoIn[RESULT_W-1]};
    diff    = shifted - {1'b0, divIn};
    // diff's top bit is the borrow: set means the trial subtraction failed
    if (!diff[RESULT_W]) begin
      remOut = diff[RESULT_W-1:0];
      quoOut = {quoIn[RESULT_W-2:0], 1'b1};
    end else begin
      remOut = shifted[RESULT_W-1:0];
      quoOut = {quoIn[RESULT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remReg  <= '0;
      quoReg  <= '0;
      divReg  <= '0;
      cntReg  <= '0;
      runReg  <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (load) begin
        remReg  <= remOut;
        quoReg  <= quoOut;
        divReg  <= divisor;
        cntReg  <= CNT_W'(1);
        runReg  <= (RESULT_W > 1);
        doneReg <= (RESULT_W == 1);
      end else if (runReg) begin
        remReg <= remOut;
        quoReg <= quoOut;
        cntReg <= cntReg + 1'b1;
        if (cntReg == CNT_W'(RESULT_W - 1)) begin
          runReg  <= 1'b0;
          doneReg <= 1'b1;
        end
      end
    end
  end

  assign done     = doneReg;
  assign quotient = quoReg;
endmodule

// File: rtl/cursor_measure_engine.sv
// Cursor measurement engine: delta-time, delta-voltage or frequency from the
// latched cursor pair. Define MEASURE_AUTO_EN to add the autoRun refresh input.
module cursor_measure_engine
  import measure_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int COORD_W  = MEAS_COORD_W,
  parameter int SHIFT_W  = 4,
  parameter int RATE_W   = 6,
  parameter int RESULT_W = MEAS_RESULT_W,
  parameter int FREQ_NUM = 10000
) (
  input  logic clock,
  input  logic reset,
`ifdef MEASURE_AUTO_EN
  input  logic autoRun,
`endif
  cursor_measure_engine_if.slave bus
);
  localparam int WSEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = COORD_W + RATE_W + SHIFT_W + 2;

  meas_state_e               stateReg, stateNext;
  meas_mode_e                modeReg;
  logic [WSEL_W-1:0]         wselReg;
  logic [COORD_W-1:0]        x1Reg, x2Reg, y1Reg, y2Reg;
  logic [NUM_CH*SHIFT_W-1:0] shiftReg;
  logic [NUM_CH*RATE_W-1:0]  rateReg;
  logic [COORD_W-1:0]        dxReg, dxNext, dyReg, dyNext;
  logic [RESULT_W-1:0]       valueReg, valueNext, resultReg, resultNext;
  logic                      ovfReg, ovfNext, overflowReg, overflowNext;
  logic                      validReg, validNext, busyReg, busyNext;
  logic                      rearmReg, rearmNext;
  logic                      latchNow, divLoad, divDone;
  logic [RESULT_W-1:0]       divQuotient;

  logic [SHIFT_W-1:0]  shiftArr [NUM_CH];
  logic [RATE_W-1:0]   rateArr  [NUM_CH];
  logic [SHIFT_W-1:0]  shiftSel;
  logic [RATE_W-1:0]   rateSel;
  logic [PROD_W-1:0]   timeProd, voltProd;
  logic [RESULT_W-1:0] scaleValue;
  logic                scaleOvf, chanValid;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign shiftArr[gi] = shiftReg[gi*SHIFT_W +: SHIFT_W];
    assign rateArr[gi]  = rateReg[gi*RATE_W +: RATE_W];
  end

  assign chanValid = (int'(wselReg) < NUM_CH);

  // Scaling from the latched channel settings; products kept at full width
  always_comb begin
    shiftSel   = shiftArr[wselReg];
    rateSel    = rateArr[wselReg];
    timeProd   = PROD_W'(dxReg) * (PROD_W'(rateSel) + PROD_W'(1));
    voltProd   = (PROD_W'(dyReg) * (PROD_W'(shiftSel) + PROD_W'(1))) << 1;
    scaleValue = '0;
    scaleOvf   = 1'b0;
    if (!chanValid) begin
      scaleValue = '1;
      scaleOvf   = 1'b1;
    end else begin
      case (modeReg)
        MEAS_TIME: begin
          scaleOvf   = sat_overflow(64'(timeProd), RESULT_W);
          scaleValue = scaleOvf ? '1 : timeProd[RESULT_W-1:0];
        end
        MEAS_VOLT: begin
          scaleOvf   = sat_overflow(64'(voltProd), RESULT_W);
          scaleValue = scaleOvf ? '1 : voltProd[RESULT_W-1:0];
        end
        MEAS_FREQ: begin
          if (timeProd == '0) begin
            scaleValue = '1;
            scaleOvf   = 1'b1;
          end else begin
            scaleOvf   = sat_overflow(64'(timeProd), RESULT_W);
            scaleValue = scaleOvf ? '1 : timeProd[RESULT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext    = stateReg;
    latchNow     = 1'b0;
    divLoad      = 1'b0;
    dxNext       = dxReg;
    dyNext       = dyReg;
    valueNext    = valueReg;
    ovfNext      = ovfReg;
    resultNext   = resultReg;
    overflowNext = overflowReg;
    validNext    = 1'b0;
    busyNext     = busyReg;
    rearmNext    = rearmReg;
    case (stateReg)
      IDLE: begin
        if (bus.start || rearmReg) begin
          latchNow  = 1'b1;
          busyNext  = 1'b1;
          rearmNext = 1'b0;
          stateNext = DELTA;
        end
      end
      DELTA: begin
        dxNext    = (x1Reg >= x2Reg) ? (x1Reg - x2Reg) : (x2Reg - x1Reg);
        dyNext    = (y1Reg >= y2Reg) ? (y1Reg - y2Reg) : (y2Reg - y1Reg);
        stateNext = SCALE;
      end
      SCALE: begin
        valueNext = scaleValue;
        ovfNext   = scaleOvf;
        // Zero period and invalid channel already carry their final value
        if (modeReg == MEAS_FREQ && chanValid && timeProd != '0) begin
          divLoad   = 1'b1;
          stateNext = DIVIDE;
        end else begin
          stateNext = DONE;
        end
      end
      DIVIDE: begin
        if (divDone) begin
          valueNext = divQuotient;
          stateNext = DONE;
        end
      end
      DONE: begin
        resultNext   = valueReg;
        overflowNext = ovfReg;
        validNext    = 1'b1;
        busyNext     = 1'b0;
        stateNext    = IDLE;
`ifdef MEASURE_AUTO_EN
        rearmNext    = autoRun;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg    <= IDLE;
      modeReg     <= MEAS_NONE;
      wselReg     <= '0;
      x1Reg       <= '0;
      x2Reg       <= '0;
      y1Reg       <= '0;
      y2Reg       <= '0;
      shiftReg    <= '0;
      rateReg     <= '0;
      dxReg       <= '0;
      dyReg       <= '0;
      valueReg    <= '0;
      ovfReg      <= 1'b0;
      resultReg   <= '0;
      overflowReg <= 1'b0;
      validReg    <= 1'b0;
      busyReg     <= 1'b0;
      rearmReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      dxReg       <= dxNext;
      dyReg       <= dyNext;
      valueReg    <= valueNext;
      ovfReg      <= ovfNext;
      resultReg   <= resultNext;
      overflowReg <= overflowNext;
      validReg    <= validNext;
      busyReg     <= busyNext;
      rearmReg    <= rearmNext;
      if (latchNow) begin
        modeReg  <= meas_mode_e'(bus.measurement);
        wselReg  <= bus.waveSel;
        x1Reg    <= bus.cursorx1;
        x2Reg    <= bus.cursorx2;
        y1Reg    <= bus.cursory1;
        y2Reg    <= bus.cursory2;
        shiftReg <= bus.shiftDown;
        rateReg  <= bus.sampleAdjust;
      end
    end
  end

  measure_divider #(.RESULT_W(RESULT_W)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .load     (divLoad),
    .dividend (RESULT_W'(FREQ_NUM)),
    .divisor  (scaleValue),
    .done     (divDone),
    .quotient (divQuotient)
  );

  assign bus.busy        = busyReg;
  assign bus.resultValid = validReg;
  assign bus.result      = resultReg;
  assign bus.overflow    = overflowReg;
endmodule

// File: tb/tb_cursor_measure_engine.sv
// Directed test of cursor_measure_engine: modes, saturation, divide, busy and
// reset behaviour, plus the autoRun refresh when MEASURE_AUTO_EN is defined.
module tb_cursor_measure_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef MEASURE_AUTO_EN
  logic autoRun = 1'b0;
`endif
  int total = 0;
  int bad   = 0;

  cursor_measure_engine_if #(.NUM_CH(2), .COORD_W(11), .SHIFT_W(4), .RATE_W(6), .RESULT_W(14)) bus ();

  cursor_measure_engine #(
    .NUM_CH(2), .COORD_W(11), .SHIFT_W(4), .RATE_W(6), .RESULT_W(14), .FREQ_NUM(10000)
  ) dut (
    .clock   (clock),
    .reset   (reset),
`ifdef MEASURE_AUTO_EN
    .autoRun (autoRun),
`endif
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic wsel,
                       input logic [10:0] x1, input logic [10:0] x2,
                       input logic [10:0] y1, input logic [10:0] y2,
                       input logic [7:0] shift, input logic [11:0] rate);
    bus.measurement  = mode;
    bus.waveSel      = wsel;
    bus.cursorx1     = x1;
    bus.cursorx2     = x2;
    bus.cursory1     = y1;
    bus.cursory2     = y2;
    bus.shiftDown    = shift;
    bus.sampleAdjust = rate;
  endtask

  // Start one measurement, scramble inputs after acceptance, wait for resultValid.
  task automatic run(input logic [1:0] mode, input logic wsel,
                     input logic [10:0] x1, input logic [10:0] x2,
                     input logic [10:0] y1, input logic [10:0] y2,
                     input logic [7:0] shift, input logic [11:0] rate,
                     output int lat, output logic busyAcc, output logic busyEnd);
    @(negedge clock);
    drive(mode, wsel, x1, x2, y1, y2, shift, rate);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    busyAcc = bus.busy;
    drive(~mode, ~wsel, ~x1, x1, ~y2, y1, ~shift, ~rate);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.resultValid) begin
        lat = n;
        break;
      end
    end
    busyEnd = bus.busy;
    $display("meas mode=%0d x1=%0d x2=%0d y1=%0d y2=%0d lat=%0d result=%0d ovf=%0d",
             mode, x1, x2, y1, y2, lat, bus.result, bus.overflow);
  endtask

  initial begin
    int   lat, nvalid;
    logic bA, bE;
    logic [13:0] got;
    bus.start = 1'b0;
    drive(2'd0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0, 8'd0, 12'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.resultValid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(negedge clock);
    reset = 1'b0;

    // Voltage on channel 1: 60*(3+1)*2
    run(2'd2, 1'b1, 11'd0, 11'd0, 11'd100, 11'd40, 8'h30, 12'h000, lat, bA, bE);
    chk("volt_lat", lat, 3);
    chk("volt_result", bus.result, 480);
    chk("volt_ovf", bus.overflow, 0);
    chk("volt_busy_acc", bA, 1);
    chk("volt_busy_end", bE, 0);
    @(posedge clock);
    #1;
    chk("volt_pulse", bus.resultValid, 0);

    // Time: 240*(4+1), both cursor orders
    run(2'd1, 1'b0, 11'd10, 11'd250, 11'd0, 11'd0, 8'h00, 12'h004, lat, bA, bE);
    chk("time_lat", lat, 3);
    chk("time_result", bus.result, 1200);
    run(2'd1, 1'b0, 11'd250, 11'd10, 11'd0, 11'd0, 8'h00, 12'h004, lat, bA, bE);
    chk("time_swap_result", bus.result, 1200);
    // Channel 1 rate 1 vs channel 0 rate 4: 240*2
    run(2'd1, 1'b1, 11'd10, 11'd250, 11'd0, 11'd0, 8'h00, 12'h044, lat, bA, bE);
    chk("time_ch1_result", bus.result, 480);

    // Frequency: 10000/100 and 10000/(1*3)
    run(2'd3, 1'b0, 11'd300, 11'd200, 11'd0, 11'd0, 8'h00, 12'h000, lat, bA, bE);
    chk("freq_lat", lat, 17);
    chk("freq_result", bus.result, 100);
    chk("freq_ovf", bus.overflow, 0);
    run(2'd3, 1'b0, 11'd6, 11'd7, 11'd0, 11'd0, 8'h00, 12'h002, lat, bA, bE);
    chk("freq3_lat", lat, 17);
    chk("freq3_result", bus.result, 3333);

    // Zero period skips the divide
    run(2'd3, 1'b0, 11'd55, 11'd55, 11'd0, 11'd0, 8'h00, 12'h000, lat, bA, bE);
    chk("fzero_lat", lat, 3);
    chk("fzero_result", bus.result, 16383);
    chk("fzero_ovf", bus.overflow, 1);

    // Saturation: 2047*16*2, then mode 0 clears
    run(2'd2, 1'b0, 11'd0, 11'd0, 11'd2047, 11'd0, 8'h0F, 12'h000, lat, bA, bE);
    chk("vsat_result", bus.result, 16383);
    chk("vsat_ovf", bus.overflow, 1);
    run(2'd0, 1'b0, 11'd5, 11'd9, 11'd3, 11'd1, 8'h0F, 12'h000, lat, bA, bE);
    chk("none_lat", lat, 3);
    chk("none_result", bus.result, 0);
    chk("none_ovf", bus.overflow, 0);

    // Start pulsed during DIVIDE must be ignored
    @(negedge clock);
    drive(2'd3, 1'b0, 11'd300, 11'd200, 11'd0, 11'd0, 8'h00, 12'h000);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    drive(2'd2, 1'b1, 11'd0, 11'd0, 11'd100, 11'd40, 8'h30, 12'h000);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    nvalid = 0;
    got = '0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clock);
      #1;
      if (bus.resultValid) begin
        nvalid++;
        got = bus.result;
      end
    end
    $display("midstart valids=%0d result=%0d", nvalid, got);
    chk("midstart_count", nvalid, 1);
    chk("midstart_result", got, 100);

    // Saturated time (2047*64) leaves result/overflow nonzero before the reset test
    run(2'd1, 1'b1, 11'd2047, 11'd0, 11'd0, 11'd0, 8'h00, 12'hFC0, lat, bA, bE);
    chk("tsat_result", bus.result, 16383);
    chk("tsat_ovf", bus.overflow, 1);

    // Reset during divide cycle 5
    @(negedge clock);
    drive(2'd3, 1'b0, 11'd300, 11'd200, 11'd0, 11'd0, 8'h00, 12'h000);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clock);
      #1;
      if (bus.resultValid) nvalid++;
    end
    $display("midreset valids=%0d result=%0d busy=%0d", nvalid, bus.result, bus.busy);
    chk("midreset_count", nvalid, 0);
    chk("midreset_result", bus.result, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_ovf", bus.overflow, 0);

    run(2'd2, 1'b1, 11'd0, 11'd0, 11'd40, 11'd100, 8'h30, 12'h000, lat, bA, bE);
    chk("recover_result", bus.result, 480);

`ifdef MEASURE_AUTO_EN
    // Continuous refresh: valid every 4 cycles, next result tracks new x2
    @(negedge clock);
    drive(2'd1, 1'b0, 11'd10, 11'd250, 11'd0, 11'd0, 8'h00, 12'h004);
    autoRun = 1'b1;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.resultValid) begin
        lat = n;
        break;
      end
    end
    chk("auto_first_result", bus.result, 1200);
    bus.cursorx2 = 11'd200;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.resultValid) begin
        lat = n;
        break;
      end
    end
    $display("auto interval=%0d result=%0d", lat, bus.result);
    chk("auto_interval", lat, 4);
    chk("auto_track_result", bus.result, 950);
    autoRun = 1'b0;
    repeat (12) @(posedge clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
